// File: rtl/id_stage.sv
// RV32I decode stage: combinational decoder feeding a single output register
// with a valid/ready handshake, flush, and synchronous reset.
module id_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_imm,
  output logic [3:0]  out_operation,
  output logic        out_asel,
  output logic        out_bsel,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic        out_regwen,
  output logic        out_illegal
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        asel;
    logic        bsel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwen;
    logic        illegal;
  } bundle_t;

  localparam logic [3:0] OP_ADD = 4'b0000, OP_SUB = 4'b0001, OP_AND = 4'b0010,
                         OP_OR  = 4'b0011, OP_SLL = 4'b0100, OP_SRL = 4'b0101,
                         OP_SRA = 4'b0110, OP_SLTU = 4'b0111, OP_SLT = 4'b1000;

  bundle_t     dec, q;
  logic        vld, accept, ill;
  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic        f7z, f7a;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

  assign opc    = in_instr[6:0];
  assign f3     = in_instr[14:12];
  assign f7     = in_instr[31:25];
  assign f7z    = (f7 == 7'b0000000);
  assign f7a    = (f7 == 7'b0100000);
  assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
  assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
  assign imm_u  = {in_instr[31:12], 12'b0};
  assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
  assign imm_sh = {27'b0, in_instr[24:20]};

  always_comb begin
    ill        = 1'b0;
    dec.pc     = in_pc;
    dec.imm    = 32'b0;
    dec.op     = OP_ADD;
    dec.asel   = 1'b0;
    dec.bsel   = 1'b1;
    dec.rs1    = in_instr[19:15];
    dec.rs2    = in_instr[24:20];
    dec.rd     = in_instr[11:7];
    dec.regwen = 1'b0;
    case (opc)
      7'b0110011: begin
        dec.bsel   = 1'b0;
        dec.regwen = 1'b1;
        case (f3)
          3'b000: if (f7z) dec.op = OP_ADD; else if (f7a) dec.op = OP_SUB; else ill = 1'b1;
          3'b001: if (f7z) dec.op = OP_SLL; else ill = 1'b1;
          3'b010: if (f7z) dec.op = OP_SLT; else ill = 1'b1;
          3'b011: if (f7z) dec.op = OP_SLTU; else ill = 1'b1;
          3'b101: if (f7z) dec.op = OP_SRL; else if (f7a) dec.op = OP_SRA; else ill = 1'b1;
          3'b110: if (f7z) dec.op = OP_OR; else ill = 1'b1;
          3'b111: if (f7z) dec.op = OP_AND; else ill = 1'b1;
          default: ill = 1'b1;  // xor has no ALU op
        endcase
      end
      7'b0010011: begin
        dec.regwen = 1'b1;
        dec.imm    = imm_i;
        case (f3)
          3'b000: dec.op = OP_ADD;
          3'b010: dec.op = OP_SLT;
          3'b011: dec.op = OP_SLTU;
          3'b110: dec.op = OP_OR;
          3'b111: dec.op = OP_AND;
          3'b001: begin dec.imm = imm_sh; if (f7z) dec.op = OP_SLL; else ill = 1'b1; end
          3'b101: begin
            dec.imm = imm_sh;
            if (f7z) dec.op = OP_SRL; else if (f7a) dec.op = OP_SRA; else ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      7'b0110111: begin dec.rs1 = 5'd0; dec.imm = imm_u; dec.regwen = 1'b1; end
      7'b0010111: begin dec.asel = 1'b1; dec.imm = imm_u; dec.regwen = 1'b1; end
      7'b1101111: begin dec.asel = 1'b1; dec.imm = imm_j; dec.regwen = 1'b1; end
      7'b1100111: begin
        dec.imm = imm_i; dec.regwen = 1'b1;
        if (f3 != 3'b000) ill = 1'b1;
      end
      7'b1100011: begin dec.asel = 1'b1; dec.imm = imm_b; end
      7'b0000011: begin dec.imm = imm_i; dec.regwen = 1'b1; end
      7'b0100011: dec.imm = imm_s;
      default:    ill = 1'b1;
    endcase
    // Illegal bundles carry no operand selection so execute treats them as inert.
    if (ill) begin
      dec.op = OP_ADD; dec.imm = 32'b0; dec.regwen = 1'b0;
      dec.asel = 1'b0; dec.bsel = 1'b0;
    end
    if (dec.rd == 5'd0) dec.regwen = 1'b0;
    dec.illegal = ill;
  end

  assign in_ready = (!vld || out_ready) && !flush;
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld <= 1'b0;
      q   <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (accept) begin
      vld <= 1'b1;
      q   <= dec;
    end else if (out_ready) begin
      vld <= 1'b0;
    end
  end

  assign out_valid     = vld;
  assign out_pc        = q.pc;
  assign out_imm       = q.imm;
  assign out_operation = q.op;
  assign out_asel      = q.asel;
  assign out_bsel      = q.bsel;
  assign out_rs1       = q.rs1;
  assign out_rs2       = q.rs2;
  assign out_rd        = q.rd;
  assign out_regwen    = q.regwen;
  assign out_illegal   = q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: stimulus pushes mnemonic-level reference
// decodes, a negedge monitor compares presented bundles and handshake signals.
module tb_id_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] imm;
    logic [3:0]  op;
    logic        asel;
    logic        bsel;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        regwen;
    logic        illegal;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] in_instr, in_pc, out_pc, out_imm;
  logic [3:0]  out_operation;
  logic        out_asel, out_bsel, out_regwen, out_illegal;
  logic [4:0]  out_rs1, out_rs2, out_rd;

  id_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_imm(out_imm), .out_operation(out_operation),
    .out_asel(out_asel), .out_bsel(out_bsel),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_regwen(out_regwen), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  exp_t sb[$];
  int   nvec = 0, nerr = 0;
  bit   mon_en = 1'b0, zero_chk = 1'b0;

  // Reference decode: one row per RV32I mnemonic, immediates by arithmetic.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    int   s;
    byte  fmt;   // R I S B U J H(shift) X(illegal)
    logic [3:0] op;
    logic is_auipc, is_lui;
    s = $signed(ins);
    op = 4'd0; is_auipc = 1'b0; is_lui = 1'b0;
    casez ({ins[31:25], ins[14:12], ins[6:0]})
      17'b0000000_000_0110011: begin fmt = "R"; op = 4'd0; end
      17'b0100000_000_0110011: begin fmt = "R"; op = 4'd1; end
      17'b0000000_001_0110011: begin fmt = "R"; op = 4'd4; end
      17'b0000000_010_0110011: begin fmt = "R"; op = 4'd8; end
      17'b0000000_011_0110011: begin fmt = "R"; op = 4'd7; end
      17'b0000000_101_0110011: begin fmt = "R"; op = 4'd5; end
      17'b0100000_101_0110011: begin fmt = "R"; op = 4'd6; end
      17'b0000000_110_0110011: begin fmt = "R"; op = 4'd3; end
      17'b0000000_111_0110011: begin fmt = "R"; op = 4'd2; end
      17'b???????_000_0010011: begin fmt = "I"; op = 4'd0; end
      17'b???????_010_0010011: begin fmt = "I"; op = 4'd8; end
      17'b???????_011_0010011: begin fmt = "I"; op = 4'd7; end
      17'b???????_110_0010011: begin fmt = "I"; op = 4'd3; end
      17'b???????_111_0010011: begin fmt = "I"; op = 4'd2; end
      17'b0000000_001_0010011: begin fmt = "H"; op = 4'd4; end
      17'b0000000_101_0010011: begin fmt = "H"; op = 4'd5; end
      17'b0100000_101_0010011: begin fmt = "H"; op = 4'd6; end
      17'b???????_???_0110111: begin fmt = "U"; is_lui = 1'b1; end
      17'b???????_???_0010111: begin fmt = "U"; is_auipc = 1'b1; end
      17'b???????_???_1101111: fmt = "J";
      17'b???????_000_1100111: fmt = "I";
      17'b???????_???_1100011: fmt = "B";
      17'b???????_???_0000011: fmt = "I";
      17'b???????_???_0100011: fmt = "S";
      default:                 fmt = "X";
    endcase
    e.pc  = pc;
    e.rs1 = is_lui ? 5'd0 : ins[19:15];
    e.rs2 = ins[24:20];
    e.rd  = ins[11:7];
    e.op  = op;
    e.illegal = (fmt == "X");
    e.asel = (fmt == "B") || (fmt == "J") || is_auipc;
    e.bsel = (fmt != "R") && (fmt != "X");
    e.regwen = (fmt != "S") && (fmt != "B") && (fmt != "X") && (ins[11:7] != 5'd0);
    case (fmt)
      "I":     e.imm = s >>> 20;
      "H":     e.imm = int'(ins[24:20]);
      "S":     e.imm = (s >>> 25) * 32 + int'(ins[11:7]);
      "B":     e.imm = (s >>> 31) * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      "U":     e.imm = ins & 32'hFFFF_F000;
      "J":     e.imm = (s >>> 31) * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: e.imm = 32'd0;
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compares whatever the DUT presents against the scoreboard head.
  always @(negedge clk) begin
    exp_t got;
    logic exp_rdy;
    if (mon_en) begin
      got = '{out_pc, out_imm, out_operation, out_asel, out_bsel,
              out_rs1, out_rs2, out_rd, out_regwen, out_illegal};
      exp_rdy = (sb.size() == 0 || out_ready) && !flush;
      chk("in_ready", 128'(in_ready), 128'(exp_rdy));
      chk("out_valid", 128'(out_valid), 128'(sb.size() != 0));
      if (zero_chk)
        chk("reset_zero", 128'({out_valid, got}), 128'(0));
      if (sb.size() != 0) begin
        chk("bundle", 128'(got), 128'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic step(input logic r, input logic iv, input logic [31:0] ins,
                      input logic [31:0] pc, input logic ordy, input logic fl);
    logic acc;
    rst = r; in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
    acc = iv && !fl && !r && (sb.size() == 0 || ordy);
    @(posedge clk);
    #1;
    zero_chk = r;
    if (r || fl) sb.delete();
    if (acc) sb.push_back(ref_decode(ins, pc));
    mon_en = 1'b1;
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0]  opcs [10];
    logic [31:0] w;
    int          k;
    opcs = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b1101111,
             7'b1100111, 7'b1100011, 7'b0000011, 7'b0100011, 7'b0};
    w = $urandom();
    k = $urandom_range(0, 9);
    w[6:0] = (k == 9) ? 7'($urandom()) : opcs[k];
    case ($urandom_range(0, 3))
      0: w[31:25] = 7'b0000000;
      1: w[31:25] = 7'b0100000;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    step(1, 0, 0, 0, 1, 0);
    step(1, 0, 0, 0, 1, 0);
    // addi, sub, srai, xor back to back
    step(0, 1, 32'h0050_0093, 32'h100, 1, 0);
    step(0, 1, 32'h4020_81B3, 32'h104, 1, 0);
    step(0, 1, 32'h4032_D293, 32'h108, 1, 0);
    step(0, 1, 32'h0020_C1B3, 32'h10C, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // backpressure: second input waits, then follows next cycle
    step(0, 1, 32'h0050_0093, 32'h200, 0, 0);
    step(0, 1, 32'h4020_81B3, 32'h204, 0, 0);
    step(0, 1, 32'h4020_81B3, 32'h204, 0, 0);
    step(0, 1, 32'h4020_81B3, 32'h204, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    // flush with a held bundle and a pending input
    step(0, 1, 32'h0050_0093, 32'h300, 0, 0);
    step(0, 1, 32'h4032_D293, 32'h304, 0, 1);
    step(0, 0, 0, 0, 1, 0);
    // reset while stalled
    step(0, 1, 32'h0041_2283, 32'h400, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 70), rand_instr(),
           $urandom() & 32'hFFFF_FFFC, ($urandom_range(0, 99) < 60),
           ($urandom_range(0, 99) < 5));
    end
    step(0, 0, 0, 0, 1, 0);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
